// File: rtl/nearest_hit_selector_pkg.sv
// nearest_hit_selector_pkg: shared widths, recoded-double field codes
// and FSM state type for the nearest hit selector.
package nearest_hit_selector_pkg;

  localparam int REC_W   = 65;
  localparam int ID_W    = 16;
  localparam int CODE_HI = 63;
  localparam int CODE_LO = 61;

  localparam logic [2:0] CODE_NAN  = 3'h7;
  localparam logic [2:0] CODE_INF  = 3'h6;
  localparam logic [2:0] CODE_ZERO = 3'h0;

  localparam logic [REC_W-1:0] REC_ZERO = '0;

  typedef enum logic {
    ACC,
    OUT
  } state_t;

  function automatic logic is_nan(
    input logic [REC_W-1:0] v
  );
    return v[CODE_HI:CODE_LO] == CODE_NAN;
  endfunction

endpackage

// File: rtl/nearest_hit_selector_if.sv
// nearest_hit_selector_if: candidate-in and result-out handshakes.
// master drives candidates and consumes results; slave is the selector.
interface nearest_hit_selector_if
  import nearest_hit_selector_pkg::*;
();

  logic             in_valid;
  logic             in_ready;
  logic [REC_W-1:0] in_t;
  logic [ID_W-1:0]  in_id;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic             out_hit;
  logic [REC_W-1:0] out_t;
  logic [ID_W-1:0]  out_id;
  logic             out_invalid;

  modport master (
    output in_valid,
    output in_t,
    output in_id,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_hit,
    input  out_t,
    input  out_id,
    input  out_invalid
  );

  modport slave (
    input  in_valid,
    input  in_t,
    input  in_id,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_hit,
    output out_t,
    output out_id,
    output out_invalid
  );

endinterface

// File: rtl/nearest_hit_selector_cmp.sv
// nearest_hit_selector_cmp: combinational recoded-double a < b compare.
// lt is a signalling compare, so any NaN operand raises invalid.
module nearest_hit_selector_cmp
  import nearest_hit_selector_pkg::*;
(
  input  logic [REC_W-1:0] a,
  input  logic [REC_W-1:0] b,
  output logic             lt,
  output logic             invalid
);

  logic       sa;
  logic       sb;
  logic [2:0] ca;
  logic [2:0] cb;
  logic       nan_a;
  logic       nan_b;
  logic       both_zero;
  logic       both_inf;
  logic       mag_lt;
  logic       mag_gt;
  logic       ordered;

  assign sa = a[REC_W-1];
  assign sb = b[REC_W-1];
  assign ca = a[CODE_HI:CODE_LO];
  assign cb = b[CODE_HI:CODE_LO];

  assign nan_a     = ca == CODE_NAN;
  assign nan_b     = cb == CODE_NAN;
  assign both_zero = (ca == CODE_ZERO) && (cb == CODE_ZERO);
  assign both_inf  = (ca == CODE_INF) && (cb == CODE_INF);
  assign ordered   = !nan_a && !nan_b;

  // Recoded exp:sig is monotonic in magnitude; equal infinities tie.
  always_comb begin
    mag_lt = 1'b0;
    mag_gt = 1'b0;
    if (!both_inf) begin
      mag_lt = a[REC_W-2:0] < b[REC_W-2:0];
      mag_gt = a[REC_W-2:0] > b[REC_W-2:0];
    end
  end

  // Zeros of either sign compare equal; otherwise order by sign then mag.
  always_comb begin
    lt = 1'b0;
    if (ordered && !both_zero) begin
      unique case (1'b1)
        (sa && !sb): lt = 1'b1;
        (sa && sb):  lt = mag_gt;
        (!sa && !sb): lt = mag_lt;
        default:     lt = 1'b0;
      endcase
    end
  end

  assign invalid = nan_a || nan_b;

endmodule

// File: rtl/nearest_hit_selector.sv
// nearest_hit_selector: per group, keeps the smallest t above t_eps
// (earliest wins ties) and returns it with its id and a NaN flag.
module nearest_hit_selector
  import nearest_hit_selector_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [REC_W-1:0]       t_eps,
  nearest_hit_selector_if.slave  bus
);

  state_t           state_q;
  state_t           state_d;

  logic             s1_valid;
  logic             s1_last;
  logic [REC_W-1:0] s1_t;
  logic [ID_W-1:0]  s1_id;

  logic             best_valid;
  logic [REC_W-1:0] best_t;
  logic [ID_W-1:0]  best_id;
  logic             nan_seen;

  logic             in_rdy;
  logic             accept;
  logic             eval;
  logic             qualify;
  logic             out_fire;
  logic             lt_eps;
  logic             inv_eps;
  logic             lt_best;
  logic             inv_best;

  nearest_hit_selector_cmp u_cmp_eps (
    .a       (t_eps),
    .b       (s1_t),
    .lt      (lt_eps),
    .invalid (inv_eps)
  );

  nearest_hit_selector_cmp u_cmp_best (
    .a       (s1_t),
    .b       (best_t),
    .lt      (lt_best),
    .invalid (inv_best)
  );

  assign in_rdy = reset_n && (state_q == ACC)
               && !(s1_valid && s1_last);
  assign accept   = bus.in_valid && in_rdy;
  assign eval     = (state_q == ACC) && s1_valid;
  assign qualify  = eval && !is_nan(s1_t) && lt_eps
                 && (!best_valid || lt_best);
  assign out_fire = (state_q == OUT) && bus.out_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ACC;
    else          state_q <= state_d;
  end

  // Leave ACC once the last beat is evaluated; return on result handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC: if (eval && s1_last) state_d = OUT;
      OUT: if (bus.out_ready)   state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // Stage S1: one captured beat, evaluated on the following edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_t     <= REC_ZERO;
      s1_id    <= '0;
    end else if (state_q == ACC) begin
      s1_valid <= accept;
      if (accept) begin
        s1_last <= bus.in_last;
        s1_t    <= bus.in_t;
        s1_id   <= bus.in_id;
      end
    end
  end

  // Running best and NaN flag; cleared once the result is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_valid <= 1'b0;
      best_t     <= REC_ZERO;
      best_id    <= '0;
      nan_seen   <= 1'b0;
    end else if (out_fire) begin
      best_valid <= 1'b0;
      best_t     <= REC_ZERO;
      best_id    <= '0;
      nan_seen   <= 1'b0;
    end else if (eval) begin
      if (qualify) begin
        best_valid <= 1'b1;
        best_t     <= s1_t;
        best_id    <= s1_id;
      end
      nan_seen <= nan_seen || inv_eps || inv_best;
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.out_valid   = state_q == OUT;
  assign bus.out_hit     = bus.out_valid && best_valid;
  assign bus.out_t       = bus.out_hit ? best_t : REC_ZERO;
  assign bus.out_id      = bus.out_hit ? best_id : '0;
  assign bus.out_invalid = bus.out_valid && nan_seen;

endmodule

// File: tb/tb_nearest_hit_selector.sv
// tb_nearest_hit_selector: directed and random groups checked against
// a real-valued reference model of the nearest-hit rules.
module tb_nearest_hit_selector;

  localparam logic [64:0] R_ONE  = 65'h08000000000000000;
  localparam logic [64:0] R_HALF = 65'h07FF0000000000000;
  localparam logic [64:0] R_TWO  = 65'h08010000000000000;
  localparam logic [64:0] R_MONE = 65'h18000000000000000;
  localparam logic [64:0] R_ZERO = 65'h0;
  localparam logic [64:0] R_QNAN = 65'h0E008000000000000;

  typedef struct packed {
    logic [64:0] t;
    logic [15:0] id;
  } beat_t;

  typedef struct packed {
    logic        hit;
    logic [64:0] t;
    logic [15:0] id;
    logic        inv;
  } res_t;

  logic        clk;
  logic        reset_n;
  logic [64:0] t_eps;
  int          n_cmp;
  int          n_bad;
  res_t        exp_q[$];

  nearest_hit_selector_if bus();

  nearest_hit_selector dut (
    .clk     (clk),
    .reset_n (reset_n),
    .t_eps   (t_eps),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit rnan(input logic [64:0] v);
    return v[63:61] == 3'b111;
  endfunction

  function automatic real to_real(input logic [64:0] v);
    logic [63:0] ie;
    logic [11:0] ex;
    ex = v[63:52] - 12'd1025;
    ie = {v[64], ex[10:0], v[51:0]};
    if (v[63:61] == 3'b000) return 0.0;
    if (v[63:61] == 3'b110) ie = {v[64], 11'h7FF, 52'b0};
    return $bitstoreal(ie);
  endfunction

  function automatic res_t model(input logic [64:0] eps,
                                 input beat_t g[$]);
    res_t r;
    real  best;
    real  tv;
    r = '0;
    best = 0.0;
    for (int i = 0; i < g.size(); i++) begin
      if (rnan(g[i].t) || rnan(eps)) begin
        r.inv = 1'b1;
      end else begin
        tv = to_real(g[i].t);
        if (to_real(eps) < tv && (!r.hit || tv < best)) begin
          r.hit = 1'b1;
          r.t   = g[i].t;
          r.id  = g[i].id;
          best  = tv;
        end
      end
    end
    return r;
  endfunction

  function automatic beat_t mk(input logic [64:0] t, input int id);
    beat_t b;
    b.t  = t;
    b.id = id[15:0];
    return b;
  endfunction

  function automatic logic [64:0] rnd_norm(input bit s);
    int unsigned e;
    logic [11:0] re;
    logic [1:0]  f;
    e  = 1020 + $urandom_range(0, 6);
    re = 12'(e + 1025);
    f  = 2'($urandom_range(0, 3));
    return {s, re, f, 50'b0};
  endfunction

  function automatic logic [64:0] rnd_val();
    int unsigned r;
    bit          s;
    r = $urandom_range(0, 99);
    s = ($urandom_range(0, 3) == 0);
    if (r < 8)  return {s, 64'b0};
    if (r < 13) return {s, 3'b111, 9'b0, 1'b1, 51'b0};
    if (r < 17) return {s, 3'b110, 61'b0};
    return rnd_norm(s);
  endfunction

  // Every cycle: a valid result must match the oldest expectation,
  // idle outputs must be zero and in_ready low while a result waits.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset_n) begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            chk("result", {bus.out_hit, bus.out_t, bus.out_id,
                           bus.out_invalid}, exp_q[0]);
            chk("in_ready_in_out", bus.in_ready, 0);
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end else begin
          chk("idle_zero", {bus.out_hit, bus.out_t, bus.out_id,
                            bus.out_invalid}, 0);
        end
      end
    end
  end

  task automatic send_group(input logic [64:0] eps, input beat_t g[$],
                            input int stall, input bit pre,
                            input bit gaps);
    @(negedge clk);
    t_eps = eps;
    exp_q.push_back(model(eps, g));
    for (int i = 0; i < g.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_t     = g[i].t;
      bus.in_id    = g[i].id;
      bus.in_last  = (i == g.size() - 1);
      chk("in_ready_beat", bus.in_ready, 1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (pre) bus.out_ready = 1'b1;
    chk("lat_e", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_e1", bus.out_valid, 1);
    if (!pre) begin
      repeat (stall) @(negedge clk);
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("back_to_acc", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
  endtask

  initial begin
    beat_t       g[$];
    res_t        r;
    logic [64:0] eps;
    n_cmp = 0;
    n_bad = 0;
    reset_n       = 1'b0;
    t_eps         = R_ZERO;
    bus.in_valid  = 1'b0;
    bus.in_t      = R_ZERO;
    bus.in_id     = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);

    g.delete();
    g.push_back(mk(R_ONE, 1));
    g.push_back(mk(R_HALF, 2));
    g.push_back(mk(R_TWO, 3));
    r = model(R_ZERO, g);
    chk("pin_min", r, {1'b1, R_HALF, 16'd2, 1'b0});
    send_group(R_ZERO, g, 0, 0, 0);

    g.delete();
    g.push_back(mk(R_MONE, 5));
    g.push_back(mk(R_ZERO, 6));
    r = model(R_ZERO, g);
    chk("pin_nohit", r, 83'b0);
    send_group(R_ZERO, g, 1, 0, 0);

    g.delete();
    g.push_back(mk(R_QNAN, 7));
    g.push_back(mk(R_ONE, 8));
    r = model(R_ZERO, g);
    chk("pin_nan", r, {1'b1, R_ONE, 16'd8, 1'b1});
    send_group(R_ZERO, g, 0, 1, 0);

    g.delete();
    g.push_back(mk(R_ONE, 9));
    g.push_back(mk(R_ONE, 10));
    r = model(R_ZERO, g);
    chk("pin_tie", r, {1'b1, R_ONE, 16'd9, 1'b0});
    send_group(R_ZERO, g, 5, 0, 0);

    @(negedge clk);
    t_eps = R_ZERO;
    bus.in_valid = 1'b1;
    bus.in_t     = R_ONE;
    bus.in_id    = 16'd11;
    bus.in_last  = 1'b0;
    chk("mid_beat0", bus.in_ready, 1);
    @(negedge clk);
    bus.in_t  = R_HALF;
    bus.in_id = 16'd12;
    chk("mid_beat1", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_out_after_rst", bus.out_valid, 0);
    end
    g.delete();
    g.push_back(mk(R_TWO, 4));
    r = model(R_ZERO, g);
    chk("pin_single", r, {1'b1, R_TWO, 16'd4, 1'b0});
    send_group(R_ZERO, g, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      int unsigned k;
      k = $urandom_range(0, 19);
      if (k < 8)       eps = R_ZERO;
      else if (k < 15) eps = rnd_norm(1'b0);
      else if (k < 19) eps = rnd_norm(1'b1);
      else             eps = R_QNAN;
      g.delete();
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) begin
        g.push_back(mk(rnd_val(), int'($urandom_range(0, 65535))));
      end
      if ($urandom_range(0, 2) == 0)
        send_group(eps, g, 0, 1, $urandom_range(0, 1) == 1);
      else
        send_group(eps, g, $urandom_range(0, 3), 0,
                   $urandom_range(0, 1) == 1);
    end

    repeat (3) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nearest_hit_selector.md
NEAREST_HIT_SELECTOR -- requirements
Module: nearest_hit_selector

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-002 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port t_eps, input, 65 bits: recoded double lower bound; it must be held stable while a group is in flight.
REQ-004 The module SHALL have the candidate input ports in_valid (input, 1 bit), in_ready (output, 1 bit), in_t (input, 65 bits, recoded double), in_id (input, 16 bits) and in_last (input, 1 bit, marks the final beat of a group).
REQ-005 The module SHALL have the result output ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_hit (output, 1 bit), out_t (output, 65 bits), out_id (output, 16 bits) and out_invalid (output, 1 bit, a NaN was seen in the group).

Function
REQ-006 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1; an accepted beat is captured into stage register S1 (t, id, last, valid).
REQ-007 The module SHALL have the FSM states ACC and OUT; in_ready SHALL be 1 only in ACC while S1 does not hold a last beat.
REQ-008 In ACC, each edge SHALL evaluate S1 when valid: qualifies = not NaN(S1.t) AND t_eps < S1.t AND (not best_valid OR S1.t < best_t), using hardfloat compare semantics (-0 == +0).
REQ-009 On qualify, best_t, best_id and best_valid=1 SHALL load from S1; ties SHALL keep the earlier beat (strict less-than).
REQ-010 nan_seen SHALL be set if either compare reports lt-invalid for S1.
REQ-011 When the evaluated S1 beat has last=1, the FSM SHALL go to OUT with S1 cleared, and the final best/nan_seen SHALL include that beat.
REQ-012 Latency: with the last beat accepted at edge E, out_valid SHALL be 1 after edge E+1; throughput SHALL be one beat per cycle within a group.
REQ-013 In OUT: out_valid=1, out_hit=best_valid, out_t=best_t, out_id=best_id, out_invalid=nan_seen; if best_valid=0 then out_t and out_id SHALL be 0.
REQ-014 Outputs SHALL be held stable while out_valid=1 and out_ready=0.
REQ-015 On an edge with out_valid and out_ready both 1, the FSM SHALL return to ACC and clear best_valid, best_t, best_id and nan_seen; in_ready rises the following cycle (no overlap).
REQ-016 A group of exactly one beat SHALL be legal and SHALL follow the same latency.
REQ-017 Whenever out_valid=0, out_hit, out_t, out_id and out_invalid SHALL be 0.

Reset
REQ-018 Asserting reset_n=0 SHALL immediately force state ACC, S1.valid=0, best_valid=0, nan_seen=0, best_t=0, best_id=0, out_valid=0 and in_ready=1 after release, discarding any in-flight group with no output.
REQ-019 in_ready SHALL be driven 0 while reset_n=0.

Structure
REQ-020 The shared package SHALL hold: REC_W=65, ID_W=16, the code field position [63:61], the NaN code 3'h7, the recoded zero constant, and the FSM state enum.
REQ-021 The module SHALL instantiate the existing recoded double comparator twice (eps vs t, t vs best) as combinational sub-modules, and SHALL contain no other sub-modules.

Verification
REQ-022 t_eps=0, with group {1.0 (0x08000000000000000) id1, 0.5 (0x07FF0000000000000) id2, 2.0 (0x08010000000000000) id3 last} -> out_hit=1, out_id=2, out_t=0x07FF0000000000000, out_invalid=0, with out_valid 2 edges after the last beat.
REQ-023 t_eps=0, with group {-1.0 (0x18000000000000000) id5, zero id6 last} -> out_hit=0, out_t=0, out_id=0.
REQ-024 A group containing a quiet NaN (0x0E008000000000000) id7 and then 1.0 id8 last -> out_hit=1, out_id=8, out_invalid=1.
REQ-025 A tie of 1.0 id9 and 1.0 id10 last, with out_ready held 0 for 5 cycles -> out_id=9 stable throughout, and in_ready=0 until the handshake completes.
REQ-026 Asserting reset_n mid-group after 2 beats -> no out_valid; a new single-beat group of 2.0 id4 -> out_id=4.
